// File: rtl/i2s_sample_feeder_if.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_feeder_if
// Purpose  : Bundles the sample-feeder signals: upstream handshake, frame clock
//            and underrun controls, and the registered transmitter and status
//            outputs.
// Signals  : i_* are driven toward the feeder, o_* are driven by the feeder.
//   i_in_valid        upstream pair valid
//   o_in_ready        feeder can accept a pair
//   i_in_left/right   16-bit two's complement samples
//   i_frame_clk       frame clock from the transmitter (high = left half)
//   i_clear_underrun  single-cycle clear of the sticky underrun flag
//   o_send_queue_*    registered samples to the transmitter
//   o_level           pairs stored, 0..DEPTH
//   o_underrun_pulse  one-cycle underrun indication
//   o_underrun_sticky held underrun indication
// Modports : slave  = feeder side, master = producer/transmitter side
// Revision : 1.0 - initial release
// ============================================================================
interface i2s_sample_feeder_if #(
   parameter int ADDR_W = 3
);
   logic              i_in_valid;
   logic              o_in_ready;
   logic [15:0]       i_in_left;
   logic [15:0]       i_in_right;
   logic              i_frame_clk;
   logic              i_clear_underrun;
   logic [15:0]       o_send_queue_left;
   logic [15:0]       o_send_queue_right;
   logic [ADDR_W:0]   o_level;
   logic              o_underrun_pulse;
   logic              o_underrun_sticky;

   modport slave (
      input  i_in_valid,
      output o_in_ready,
      input  i_in_left,
      input  i_in_right,
      input  i_frame_clk,
      input  i_clear_underrun,
      output o_send_queue_left,
      output o_send_queue_right,
      output o_level,
      output o_underrun_pulse,
      output o_underrun_sticky
   );

   modport master (
      output i_in_valid,
      input  o_in_ready,
      output i_in_left,
      output i_in_right,
      output i_frame_clk,
      output i_clear_underrun,
      input  o_send_queue_left,
      input  o_send_queue_right,
      input  o_level,
      input  o_underrun_pulse,
      input  o_underrun_sticky
   );
endinterface
`default_nettype wire

// File: rtl/i2s_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_feeder
// Purpose  : Stereo sample FIFO between the mixer and the I2S transmitter.
//            Pairs are pushed over valid/ready; on each rising edge of the
//            frame clock the oldest pair is loaded into the registered
//            transmitter outputs. An empty FIFO at a frame start outputs
//            silence and raises the underrun flags.
// Ports    : clk    - system clock, rising edge
//            reset  - asynchronous, active-high, clears all state
//            bus    - i2s_sample_feeder_if.slave (handshake, frame, status)
// Params   : DEPTH  - FIFO depth in pairs, power of two, 2..256
//            ADDR_W - log2(DEPTH)
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_feeder #(
   parameter int DEPTH  = 8,
   parameter int ADDR_W = 3
) (
   input  wire logic             clk,
   input  wire logic             reset,
   i2s_sample_feeder_if.slave    bus
);

   localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

   // storage and bookkeeping
   logic [31:0]       r_mem [DEPTH];
   logic [ADDR_W-1:0] r_wptr;
   logic [ADDR_W-1:0] r_rptr;
   logic [ADDR_W:0]   r_level;
   logic              r_frame_d;
   logic [15:0]       r_left;
   logic [15:0]       r_right;
   logic              r_upulse;
   logic              r_sticky;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_load;
   logic              w_pop;
   logic              w_underrun;
   logic [31:0]       w_rd_pair;

   // in_ready depends on level alone, so a pop in the same cycle never
   // lets a push into a full FIFO.
   assign w_full     = (r_level == c_DEPTH);
   assign w_empty    = (r_level == '0);
   assign w_push     = bus.i_in_valid && !w_full;
   assign w_load     = bus.i_frame_clk && !r_frame_d;
   // Emptiness is judged on the registered level: a pair pushed on the
   // same edge is not bypassed to the outputs.
   assign w_pop      = w_load && !w_empty;
   assign w_underrun = w_load && w_empty;
   assign w_rd_pair  = r_mem[r_rptr];

   // Sample array carries no reset; entries are only observable through
   // level, which reset clears.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {bus.i_in_left, bus.i_in_right};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_level   <= '0;
         r_frame_d <= 1'b0;
      end else begin
         r_frame_d <= bus.i_frame_clk;
         if (w_push) begin
            r_wptr <= r_wptr + ADDR_W'(1);
         end
         if (w_pop) begin
            r_rptr <= r_rptr + ADDR_W'(1);
         end
         // push and pop together leave the level unchanged
         case ({w_push, w_pop})
            2'b10:   r_level <= r_level + (ADDR_W+1)'(1);
            2'b01:   r_level <= r_level - (ADDR_W+1)'(1);
            default: r_level <= r_level;
         endcase
      end
   end

   // Transmitter outputs change only at a frame start and hold otherwise.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_left  <= '0;
         r_right <= '0;
      end else if (w_pop) begin
         r_left  <= w_rd_pair[31:16];
         r_right <= w_rd_pair[15:0];
      end else if (w_underrun) begin
         r_left  <= '0;
         r_right <= '0;
      end
   end

   // Underrun flags; a new underrun outranks a simultaneous clear.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_upulse <= 1'b0;
         r_sticky <= 1'b0;
      end else begin
         r_upulse <= w_underrun;
         if (w_underrun) begin
            r_sticky <= 1'b1;
         end else if (bus.i_clear_underrun) begin
            r_sticky <= 1'b0;
         end
      end
   end

   assign bus.o_in_ready         = !w_full;
   assign bus.o_send_queue_left  = r_left;
   assign bus.o_send_queue_right = r_right;
   assign bus.o_level            = r_level;
   assign bus.o_underrun_pulse   = r_upulse;
   assign bus.o_underrun_sticky  = r_sticky;

endmodule
`default_nettype wire

// File: tb/tb_i2s_sample_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_sample_feeder
// Purpose  : Directed bench for i2s_sample_feeder with a queue-based model
//            compared on every falling clock edge, plus literal expectations.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_i2s_sample_feeder;
   localparam int DEPTH = 8;
   localparam int AW    = 3;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   i2s_sample_feeder_if #(.ADDR_W(AW)) bus();

   i2s_sample_feeder #(.DEPTH(DEPTH), .ADDR_W(AW)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   int total = 0;
   int bad   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [31:0] m_q[$];
   logic [15:0] m_l, m_r;
   logic        m_pulse, m_sticky, m_prev;
   logic        m_load;
   int          m_n;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_q.delete();
         m_l = '0; m_r = '0; m_pulse = 1'b0; m_sticky = 1'b0; m_prev = 1'b0;
      end else begin
         m_load  = bus.i_frame_clk && !m_prev;
         m_n     = m_q.size();
         m_pulse = 1'b0;
         if (m_load) begin
            if (m_n > 0) begin
               {m_l, m_r} = m_q.pop_front();
            end else begin
               m_l = '0; m_r = '0; m_pulse = 1'b1;
            end
         end
         if (m_load && m_n == 0) m_sticky = 1'b1;
         else if (bus.i_clear_underrun) m_sticky = 1'b0;
         if (bus.i_in_valid && m_n < DEPTH)
            m_q.push_back({bus.i_in_left, bus.i_in_right});
         m_prev = bus.i_frame_clk;
      end
   end

   // ---------------- per-cycle compare ----------------
   always @(negedge clk) begin
      check("ready",  {31'd0, bus.o_in_ready},        {31'd0, (m_q.size() < DEPTH)});
      check("level",  {28'd0, bus.o_level},           32'(m_q.size()));
      check("left",   {16'd0, bus.o_send_queue_left},  {16'd0, m_l});
      check("right",  {16'd0, bus.o_send_queue_right}, {16'd0, m_r});
      check("upulse", {31'd0, bus.o_underrun_pulse},   {31'd0, m_pulse});
      check("sticky", {31'd0, bus.o_underrun_sticky},  {31'd0, m_sticky});
   end

   // ---------------- stimulus helpers ----------------
   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic push(input logic [15:0] l, input logic [15:0] r);
      bus.i_in_valid = 1'b1;
      bus.i_in_left  = l;
      bus.i_in_right = r;
      cyc(1);
      bus.i_in_valid = 1'b0;
   endtask

   task automatic frame_pulse();
      bus.i_frame_clk = 1'b1;
      cyc(1);
      bus.i_frame_clk = 1'b0;
      cyc(1);
   endtask

   logic [15:0] pl [3];
   logic [15:0] pr [3];

   initial begin
      pl[0] = 16'h1111; pl[1] = 16'h2222; pl[2] = 16'h3333;
      pr[0] = 16'hAAAA; pr[1] = 16'hBBBB; pr[2] = 16'hCCCC;
      reset = 1'b1;
      bus.i_in_valid = 1'b0; bus.i_in_left = '0; bus.i_in_right = '0;
      bus.i_frame_clk = 1'b0; bus.i_clear_underrun = 1'b0;
      cyc(3);
      reset = 1'b0;
      cyc(1);
      check("rst_level", {28'd0, bus.o_level}, 32'd0);
      check("rst_ready", {31'd0, bus.o_in_ready}, 32'd1);
      check("rst_left",  {16'd0, bus.o_send_queue_left}, 32'd0);

      // ordered playback, frame period 64 clocks
      for (int i = 0; i < 3; i++) push(pl[i], pr[i]);
      check("model_lvl3", 32'(m_q.size()), 32'd3);
      for (int f = 0; f < 3; f++) begin
         bus.i_frame_clk = 1'b1;
         cyc(1);
         check("play_left",  {16'd0, bus.o_send_queue_left},  {16'd0, pl[f]});
         check("play_right", {16'd0, bus.o_send_queue_right}, {16'd0, pr[f]});
         check("play_level", {28'd0, bus.o_level}, 32'(2 - f));
         cyc(31);
         check("play_hold",  {16'd0, bus.o_send_queue_left},  {16'd0, pl[f]});
         bus.i_frame_clk = 1'b0;
         cyc(32);
      end

      // underrun and sticky clear, including set-wins-over-clear
      bus.i_frame_clk = 1'b1;
      cyc(1);
      check("ur_left",   {16'd0, bus.o_send_queue_left}, 32'd0);
      check("ur_pulse",  {31'd0, bus.o_underrun_pulse}, 32'd1);
      check("ur_sticky", {31'd0, bus.o_underrun_sticky}, 32'd1);
      cyc(1);
      check("ur_pulse_gone", {31'd0, bus.o_underrun_pulse}, 32'd0);
      bus.i_frame_clk = 1'b0;
      cyc(1);
      bus.i_clear_underrun = 1'b1;
      cyc(1);
      bus.i_clear_underrun = 1'b0;
      check("ur_cleared", {31'd0, bus.o_underrun_sticky}, 32'd0);
      bus.i_frame_clk = 1'b1; bus.i_clear_underrun = 1'b1;
      cyc(1);
      bus.i_clear_underrun = 1'b0;
      check("set_wins", {31'd0, bus.o_underrun_sticky}, 32'd1);
      bus.i_frame_clk = 1'b0; bus.i_clear_underrun = 1'b1;
      cyc(1);
      bus.i_clear_underrun = 1'b0;

      // full: nine pushes, the ninth refused
      for (int i = 0; i < 9; i++) push(16'h0100 + 16'(i), 16'hF000 + 16'(i));
      check("full_level", {28'd0, bus.o_level}, 32'd8);
      check("full_ready", {31'd0, bus.o_in_ready}, 32'd0);
      bus.i_frame_clk = 1'b1;
      cyc(1);
      check("full_pop_left", {16'd0, bus.o_send_queue_left}, 32'h0100);
      check("full_pop_ready", {31'd0, bus.o_in_ready}, 32'd1);
      bus.i_frame_clk = 1'b0;
      cyc(1);
      repeat (7) frame_pulse();
      check("full_last", {16'd0, bus.o_send_queue_right}, 32'hF007);
      check("full_nopulse", {31'd0, bus.o_underrun_pulse}, 32'd0);

      // simultaneous push and load at level 1, then at level 0
      push(16'h7777, 16'h8888);
      bus.i_frame_clk = 1'b1;
      bus.i_in_valid = 1'b1; bus.i_in_left = 16'h5555; bus.i_in_right = 16'h6666;
      cyc(1);
      bus.i_in_valid = 1'b0;
      check("sim1_left",  {16'd0, bus.o_send_queue_left}, 32'h7777);
      check("sim1_level", {28'd0, bus.o_level}, 32'd1);
      bus.i_frame_clk = 1'b0;
      cyc(1);
      frame_pulse();
      check("sim1_next", {16'd0, bus.o_send_queue_right}, 32'h6666);
      bus.i_frame_clk = 1'b1;
      bus.i_in_valid = 1'b1; bus.i_in_left = 16'h9999; bus.i_in_right = 16'h1234;
      cyc(1);
      bus.i_in_valid = 1'b0;
      check("sim0_left",  {16'd0, bus.o_send_queue_left}, 32'd0);
      check("sim0_pulse", {31'd0, bus.o_underrun_pulse}, 32'd1);
      check("sim0_level", {28'd0, bus.o_level}, 32'd1);
      bus.i_frame_clk = 1'b0;
      cyc(1);
      frame_pulse();
      check("sim0_next", {16'd0, bus.o_send_queue_left}, 32'h9999);
      bus.i_clear_underrun = 1'b1;
      cyc(1);
      bus.i_clear_underrun = 1'b0;

      // wrap-around at steady level 4
      for (int i = 0; i < 4; i++) push(16'hA000 + 16'(i), 16'h5000 + 16'(i));
      for (int i = 0; i < 20; i++) begin
         bus.i_frame_clk = 1'b1;
         bus.i_in_valid = 1'b1;
         bus.i_in_left = 16'hA004 + 16'(i); bus.i_in_right = 16'h5004 + 16'(i);
         cyc(1);
         bus.i_in_valid = 1'b0;
         bus.i_frame_clk = 1'b0;
         cyc(1);
      end
      check("wrap_left",   {16'd0, bus.o_send_queue_left}, 32'hA013);
      check("wrap_level",  {28'd0, bus.o_level}, 32'd4);
      check("wrap_sticky", {31'd0, bus.o_underrun_sticky}, 32'd0);
      repeat (4) frame_pulse();
      check("wrap_last", {16'd0, bus.o_send_queue_right}, 32'h5017);

      // reset mid-run at level 5 with sticky set and outputs non-zero
      frame_pulse();
      for (int i = 0; i < 6; i++) push(16'hB000 + 16'(i), 16'hC000 + 16'(i));
      frame_pulse();
      check("pre_rst_level", {28'd0, bus.o_level}, 32'd5);
      check("pre_rst_left",  {16'd0, bus.o_send_queue_left}, 32'hB000);
      bus.i_in_valid = 1'b1; bus.i_in_left = 16'hDEAD; bus.i_in_right = 16'hBEEF;
      reset = 1'b1;
      #1;
      check("mid_rst_level",  {28'd0, bus.o_level}, 32'd0);
      check("mid_rst_left",   {16'd0, bus.o_send_queue_left}, 32'd0);
      check("mid_rst_ready",  {31'd0, bus.o_in_ready}, 32'd1);
      check("mid_rst_sticky", {31'd0, bus.o_underrun_sticky}, 32'd0);
      bus.i_frame_clk = 1'b1;
      cyc(2);
      reset = 1'b0;
      cyc(1);
      // frame already high at release: first edge loads from an empty FIFO
      check("rel_pulse", {31'd0, bus.o_underrun_pulse}, 32'd1);
      check("rel_level", {28'd0, bus.o_level}, 32'd1);
      bus.i_in_valid = 1'b0;
      bus.i_frame_clk = 1'b0;
      cyc(2);
      frame_pulse();
      check("rel_data", {16'd0, bus.o_send_queue_left}, 32'hDEAD);
      cyc(2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/i2s_sample_feeder.md
# i2s_sample_feeder

Stereo sample buffer between the synth voice/mixer output and the I2S transmitter. Accepts 16-bit left/right sample pairs over a valid/ready handshake, stores them in a small FIFO, and on each new I2S frame presents the next pair on registered `send_queue_left`/`send_queue_right` outputs, which drive the transmitter's inputs of the same name. On underrun it outputs silence and flags the event.

## Interface
- `DEPTH`, 8, FIFO depth in stereo pairs; power of two, 2..256.
- `ADDR_W`, 3, log2(`DEPTH`); must match `DEPTH`.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `in_valid`  in  1  upstream has a sample pair on `in_left`/`in_right`.
- `in_ready`  out  1  FIFO can accept a pair (`!full`).
- `in_left`  in  16  left sample, two's complement.
- `in_right`  in  16  right sample, two's complement.
- `frame_clk`  in  1  frame clock from the transmitter, synchronous to `clk`; high = left half.
- `clear_underrun`  in  1  single-cycle clear of the sticky underrun flag.
- `send_queue_left`  out  16  registered left sample to transmitter.
- `send_queue_right`  out  16  registered right sample to transmitter.
- `level`  out  ADDR_W+1  pairs currently stored, 0..`DEPTH`.
- `underrun_pulse`  out  1  high for one cycle when a frame load found the FIFO empty.
- `underrun_sticky`  out  1  set by `underrun_pulse`, held until cleared.

## Operation
- Storage: `DEPTH` x 32-bit array (`{left,right}`), write pointer, read pointer, each `ADDR_W` bits, wrapping modulo `DEPTH`; `level` register of `ADDR_W+1` bits.
- Push: `in_valid && in_ready` at a clock edge writes the pair at wptr, wptr+1, level+1.
- `in_ready = (level != DEPTH)`; combinational from `level` only, never from `frame_clk` (no push when full, even if a pop occurs the same cycle).
- Frame detect: register `frame_clk_d`; `load = frame_clk && !frame_clk_d` (rising edge = start of left half).
- On `load`:
  - level > 0: outputs <= pair at rptr, rptr+1, level-1.
  - level == 0: outputs <= 16'h0000 both, `underrun_pulse` asserted next cycle, sticky set; pointers/level unchanged.
- Simultaneous push and load with level > 0: both occur, level unchanged, pointers both advance.
- Simultaneous push and load with level == 0: underrun (no bypass); pushed pair stored, level becomes 1.
- Outputs otherwise hold their value for the whole frame (both halves).
- `clear_underrun` and a new underrun in the same cycle: sticky stays set (set wins).
- States (implicit, from `level`): EMPTY (0), PARTIAL, FULL (`DEPTH`); no other FSM.

## Timing
- Reset values: `send_queue_left`/`right` = 0, `level` = 0, `in_ready` = 1, `underrun_pulse` = 0, `underrun_sticky` = 0, pointers = 0, `frame_clk_d` = 0.
- Push-to-visible: a pair pushed at edge N is eligible for a load evaluated at edge N+1 or later.
- Load latency: `frame_clk` sampled high with `frame_clk_d` low at edge N -> outputs change at edge N (registered in the same edge the edge-detect is evaluated); visible from cycle N+1.
- `underrun_pulse` is registered: high exactly one cycle, the cycle after the failing load.
- First rising `frame_clk` after reset with `frame_clk` already high at reset release: `frame_clk_d` is 0, so a load occurs on the first clock edge.
- Reset asserted mid-frame or mid-push: all state clears immediately; no partial write survives.
- `level` updates on the same edge as the push/load; `in_ready` follows combinationally.

## Test plan
- Reset: assert `reset` mid-run with level 5 -> immediately level 0, outputs 0, `in_ready` 1, flags 0.
- Ordered playback: push (0x1111,0xAAAA),(0x2222,0xBBBB),(0x3333,0xCCCC), toggle `frame_clk` with period 64 clk -> outputs show the three pairs in order on successive rising edges of `frame_clk`, level 3->2->1->0.
- Full: push 8 pairs with no frame edges -> level 8, `in_ready` 0; ninth `in_valid` ignored; next load frees one slot, `in_ready` 1.
- Underrun: empty FIFO, rising `frame_clk` -> outputs 0x0000/0x0000, `underrun_pulse` one cycle, sticky 1; `clear_underrun` -> sticky 0.
- Simultaneous: level 1, push (0x5555,0x6666) on the load edge -> old pair output, level stays 1; level 0 same case -> underrun, level 1, pushed pair appears on next frame.
- Wrap-around: 20 push/load cycles at level ~4 -> pointers wrap past 7 with data order preserved and no spurious underrun.
